// File: rtl/hazard_ctrl.sv
// Hazard and stall sequencer for the five-stage MIPS pipeline: load-use bubbles,
// memory-wait freezes with a watchdog timeout, and a saturating stall-cycle counter.
module hazard_ctrl #(
   parameter int MEM_TIMEOUT = 16,
   parameter int CNT_W       = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [4:0]       id_rs,
   input  logic [4:0]       id_rt,
   input  logic             id_rs_used,
   input  logic             id_rt_used,
   input  logic             ex_ReadMem,
   input  logic [4:0]       ex_rt,
   input  logic             mem_req,
   input  logic             mem_ack,
   output logic             pc_en,
   output logic             ifid_en,
   output logic             idex_en,
   output logic             exmem_en,
   output logic             idex_bubble,
   output logic             memwb_bubble,
   output logic             mem_err,
   output logic [CNT_W-1:0] stall_count
);

   localparam int WC_W = $clog2(MEM_TIMEOUT + 1);

   typedef enum logic [1:0] {
      S_RUN  = 2'd0,
      S_WAIT = 2'd1,
      S_ERR  = 2'd2
   } state_t;

   state_t            state_q, state_d;
   logic [WC_W-1:0]   wait_cnt_q, wait_cnt_d;
   logic              mem_err_q, mem_err_d;
   logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;

   logic              unacked;
   logic              freeze;
   logic              load_use;
   logic [WC_W-1:0]   wait_cnt_inc;
   logic              hits_timeout;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (&v) ? v : v + CNT_W'(1);
   endfunction

   assign unacked      = mem_req & ~mem_ack;
   assign freeze       = unacked | (state_q == S_ERR);
   assign wait_cnt_inc = wait_cnt_q + WC_W'(1);
   assign hits_timeout = (wait_cnt_inc >= WC_W'(MEM_TIMEOUT));

   // Register 0 is hard-wired to zero, so a load targeting it never creates a dependency.
   assign load_use = ex_ReadMem & (ex_rt != 5'd0) &
                     ((id_rs_used & (id_rs == ex_rt)) | (id_rt_used & (id_rt == ex_rt)));

   always_comb begin
      pc_en        = 1'b1;
      ifid_en      = 1'b1;
      idex_en      = 1'b1;
      exmem_en     = 1'b1;
      idex_bubble  = 1'b0;
      memwb_bubble = 1'b0;
      if (!rst) begin
         pc_en    = 1'b0;
         ifid_en  = 1'b0;
         idex_en  = 1'b0;
         exmem_en = 1'b0;
      end else if (freeze) begin
         // Whole pipe holds; ID/EX is not bubbled so the ID instruction survives the wait.
         pc_en        = 1'b0;
         ifid_en      = 1'b0;
         idex_en      = 1'b0;
         exmem_en     = 1'b0;
         memwb_bubble = 1'b1;
      end else if (load_use) begin
         pc_en       = 1'b0;
         ifid_en     = 1'b0;
         idex_bubble = 1'b1;
      end
   end

   always_comb begin
      state_d    = state_q;
      wait_cnt_d = wait_cnt_q;
      case (state_q)
         S_RUN: begin
            if (unacked) begin
               if (hits_timeout) begin
                  state_d = S_ERR;
               end else begin
                  state_d    = S_WAIT;
                  wait_cnt_d = WC_W'(1);
               end
            end
         end
         S_WAIT: begin
            if (unacked) begin
               if (hits_timeout) begin
                  state_d = S_ERR;
               end else begin
                  wait_cnt_d = wait_cnt_inc;
               end
            end else begin
               state_d    = S_RUN;
               wait_cnt_d = '0;
            end
         end
         S_ERR: begin
            state_d = S_ERR;
         end
         default: begin
            state_d    = S_RUN;
            wait_cnt_d = '0;
         end
      endcase
      mem_err_d   = mem_err_q | (state_d == S_ERR);
      stall_cnt_d = pc_en ? stall_cnt_q : sat_inc(stall_cnt_q);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= S_RUN;
         wait_cnt_q  <= '0;
         mem_err_q   <= 1'b0;
         stall_cnt_q <= '0;
      end else begin
         state_q     <= state_d;
         wait_cnt_q  <= wait_cnt_d;
         mem_err_q   <= mem_err_d;
         stall_cnt_q <= stall_cnt_d;
      end
   end

   assign mem_err     = mem_err_q;
   assign stall_count = stall_cnt_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl (MEM_TIMEOUT=4, CNT_W=4): the driver queues hand-computed
// expectations per cycle, the monitor pops and compares them mid-cycle.
module tb_hazard_ctrl;

   logic       clk;
   logic       rst;
   logic [4:0] id_rs, id_rt, ex_rt;
   logic       id_rs_used, id_rt_used, ex_ReadMem, mem_req, mem_ack;
   logic       pc_en, ifid_en, idex_en, exmem_en, idex_bubble, memwb_bubble, mem_err;
   logic [3:0] stall_count;

   int checks = 0;
   int errors = 0;

   typedef struct {
      string      nm;
      logic [3:0] en;
      logic       ib;
      logic       mb;
      logic       me;
      logic [3:0] sc;
   } exp_t;

   exp_t exp_q[$];

   hazard_ctrl #(.MEM_TIMEOUT(4), .CNT_W(4)) dut (
      .clk          (clk),
      .rst          (rst),
      .id_rs        (id_rs),
      .id_rt        (id_rt),
      .id_rs_used   (id_rs_used),
      .id_rt_used   (id_rt_used),
      .ex_ReadMem   (ex_ReadMem),
      .ex_rt        (ex_rt),
      .mem_req      (mem_req),
      .mem_ack      (mem_ack),
      .pc_en        (pc_en),
      .ifid_en      (ifid_en),
      .idex_en      (idex_en),
      .exmem_en     (exmem_en),
      .idex_bubble  (idex_bubble),
      .memwb_bubble (memwb_bubble),
      .mem_err      (mem_err),
      .stall_count  (stall_count)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // One cycle: drive inputs 2ns after the edge, queue the expected outputs for this cycle.
   // en is {pc_en, ifid_en, idex_en, exmem_en}.
   task automatic cyc(input string nm, input logic r,
                      input logic [4:0] rs, input logic rsu, input logic [4:0] rt, input logic rtu,
                      input logic exr, input logic [4:0] ext, input logic rq, input logic ak,
                      input logic [3:0] en, input logic ib, input logic mb, input logic me,
                      input logic [3:0] sc);
      exp_t e;
      @(posedge clk);
      #2;
      rst = r; id_rs = rs; id_rs_used = rsu; id_rt = rt; id_rt_used = rtu;
      ex_ReadMem = exr; ex_rt = ext; mem_req = rq; mem_ack = ak;
      e.nm = nm; e.en = en; e.ib = ib; e.mb = mb; e.me = me; e.sc = sc;
      exp_q.push_back(e);
   endtask

   task automatic quiet(input string nm, input logic r, input logic [3:0] en,
                        input logic mb, input logic me, input logic [3:0] sc);
      cyc(nm, r, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, en, 1'b0, mb, me, sc);
   endtask

   task automatic mem(input string nm, input logic rq, input logic ak, input logic [3:0] en,
                      input logic mb, input logic me, input logic [3:0] sc);
      cyc(nm, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, rq, ak, en, 1'b0, mb, me, sc);
   endtask

   // Load into r5 in EX while ID reads r5 through rs.
   task automatic lu(input string nm, input logic rq, input logic ak, input logic [3:0] en,
                     input logic ib, input logic mb, input logic me, input logic [3:0] sc);
      cyc(nm, 1'b1, 5'd5, 1'b1, 5'd0, 1'b0, 1'b1, 5'd5, rq, ak, en, ib, mb, me, sc);
   endtask

   initial begin
      forever begin
         exp_t e;
         @(posedge clk);
         #4;
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if ({pc_en, ifid_en, idex_en, exmem_en} !== e.en || idex_bubble !== e.ib ||
                memwb_bubble !== e.mb || mem_err !== e.me || stall_count !== e.sc) begin
               errors++;
               $display("FAIL %s: got en=%b ib=%b mb=%b err=%b cnt=%0d, expected en=%b ib=%b mb=%b err=%b cnt=%0d",
                        e.nm, {pc_en, ifid_en, idex_en, exmem_en}, idex_bubble, memwb_bubble,
                        mem_err, stall_count, e.en, e.ib, e.mb, e.me, e.sc);
            end
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached, expected completion");
      $fatal(1, "time limit");
   end

   initial begin
      int drain;
      rst = 1'b0; id_rs = '0; id_rt = '0; ex_rt = '0;
      id_rs_used = 1'b0; id_rt_used = 1'b0; ex_ReadMem = 1'b0; mem_req = 1'b0; mem_ack = 1'b0;

      quiet("reset0", 1'b0, 4'b0000, 1'b0, 1'b0, 4'd0);
      quiet("reset1", 1'b0, 4'b0000, 1'b0, 1'b0, 4'd0);
      quiet("idle",   1'b1, 4'b1111, 1'b0, 1'b0, 4'd0);

      lu("lu_rs", 1'b0, 1'b0, 4'b0011, 1'b1, 1'b0, 1'b0, 4'd0);
      quiet("lu_after", 1'b1, 4'b1111, 1'b0, 1'b0, 4'd1);
      cyc("nohz_r0", 1'b1, 5'd0, 1'b1, 5'd0, 1'b0, 1'b1, 5'd0, 1'b0, 1'b0,
          4'b1111, 1'b0, 1'b0, 1'b0, 4'd1);
      cyc("nohz_rt_unused", 1'b1, 5'd0, 1'b0, 5'd7, 1'b0, 1'b1, 5'd7, 1'b0, 1'b0,
          4'b1111, 1'b0, 1'b0, 1'b0, 4'd1);
      cyc("lu_rt", 1'b1, 5'd0, 1'b0, 5'd7, 1'b1, 1'b1, 5'd7, 1'b0, 1'b0,
          4'b0011, 1'b1, 1'b0, 1'b0, 4'd1);

      mem("mw0",    1'b1, 1'b0, 4'b0000, 1'b1, 1'b0, 4'd2);
      mem("mw1",    1'b1, 1'b0, 4'b0000, 1'b1, 1'b0, 4'd3);
      mem("mw2",    1'b1, 1'b0, 4'b0000, 1'b1, 1'b0, 4'd4);
      mem("mw_ack", 1'b1, 1'b1, 4'b1111, 1'b0, 1'b0, 4'd5);
      mem("mw_run", 1'b0, 1'b0, 4'b1111, 1'b0, 1'b0, 4'd5);
      mem("ack_first", 1'b1, 1'b1, 4'b1111, 1'b0, 1'b0, 4'd5);
      mem("ack_noreq", 1'b0, 1'b1, 4'b1111, 1'b0, 1'b0, 4'd5);

      lu("fz_lu0",    1'b1, 1'b0, 4'b0000, 1'b0, 1'b1, 1'b0, 4'd5);
      lu("fz_lu1",    1'b1, 1'b0, 4'b0000, 1'b0, 1'b1, 1'b0, 4'd6);
      lu("fz_lu_ack", 1'b1, 1'b1, 4'b0011, 1'b1, 1'b0, 1'b0, 4'd7);
      quiet("fz_lu_done", 1'b1, 4'b1111, 1'b0, 1'b0, 4'd8);

      mem("late0",    1'b1, 1'b0, 4'b0000, 1'b1, 1'b0, 4'd8);
      mem("late1",    1'b1, 1'b0, 4'b0000, 1'b1, 1'b0, 4'd9);
      mem("late2",    1'b1, 1'b0, 4'b0000, 1'b1, 1'b0, 4'd10);
      mem("late3_ack",1'b1, 1'b1, 4'b1111, 1'b0, 1'b0, 4'd11);
      mem("late_run", 1'b0, 1'b0, 4'b1111, 1'b0, 1'b0, 4'd11);

      quiet("rst_a",   1'b0, 4'b0000, 1'b0, 1'b0, 4'd0);
      quiet("rel_a",   1'b1, 4'b1111, 1'b0, 1'b0, 4'd0);
      mem("to0", 1'b1, 1'b0, 4'b0000, 1'b1, 1'b0, 4'd0);
      mem("to1", 1'b1, 1'b0, 4'b0000, 1'b1, 1'b0, 4'd1);
      mem("to2", 1'b1, 1'b0, 4'b0000, 1'b1, 1'b0, 4'd2);
      mem("to3", 1'b1, 1'b0, 4'b0000, 1'b1, 1'b0, 4'd3);
      mem("to4", 1'b1, 1'b0, 4'b0000, 1'b1, 1'b1, 4'd4);
      mem("to5_noreq", 1'b0, 1'b0, 4'b0000, 1'b1, 1'b1, 4'd5);
      lu("to6_lu", 1'b0, 1'b0, 4'b0000, 1'b0, 1'b1, 1'b1, 4'd6);

      quiet("rst_err", 1'b0, 4'b0000, 1'b0, 1'b0, 4'd0);
      quiet("rel_err", 1'b1, 4'b1111, 1'b0, 1'b0, 4'd0);
      quiet("run_err", 1'b1, 4'b1111, 1'b0, 1'b0, 4'd0);

      for (int i = 0; i < 20; i++) begin
         lu("sat", 1'b0, 1'b0, 4'b0011, 1'b1, 1'b0, 1'b0, (i > 15) ? 4'd15 : 4'(i));
      end
      quiet("sat_end", 1'b1, 4'b1111, 1'b0, 1'b0, 4'd15);

      mem("mr_w0", 1'b1, 1'b0, 4'b0000, 1'b1, 1'b0, 4'd15);
      mem("mr_w1", 1'b1, 1'b0, 4'b0000, 1'b1, 1'b0, 4'd15);
      quiet("mr_rst", 1'b0, 4'b0000, 1'b0, 1'b0, 4'd0);
      quiet("mr_rel", 1'b1, 4'b1111, 1'b0, 1'b0, 4'd0);
      mem("mr0", 1'b1, 1'b0, 4'b0000, 1'b1, 1'b0, 4'd0);
      mem("mr1", 1'b1, 1'b0, 4'b0000, 1'b1, 1'b0, 4'd1);
      mem("mr2", 1'b1, 1'b0, 4'b0000, 1'b1, 1'b0, 4'd2);
      mem("mr3", 1'b1, 1'b0, 4'b0000, 1'b1, 1'b0, 4'd3);
      mem("mr4", 1'b1, 1'b0, 4'b0000, 1'b1, 1'b1, 4'd4);

      drain = 0;
      while (exp_q.size() > 0 && drain < 10) begin
         @(posedge clk);
         drain++;
      end
      if (exp_q.size() > 0) begin
         errors++;
         $display("FAIL drain: %0d expectations left unchecked, expected 0", exp_q.size());
      end
      @(posedge clk);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
